quiz_round_ctrl: RTL and testbench

Round sequencer and buzzer arbiter for the two-player quiz game. It opens a buzz window and picks the first player to buzz (round-robin on ties). It then runs the answer timer, collects the judge's verdict, and issues a one-cycle scoring command (`who`, `right`, `score_valid`) to `score_control`. It also counts rounds and flags game over.

---
 rtl/quiz_round_ctrl.sv | 154 +++++++++++++++
 tb/tb_quiz_round_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quiz_round_ctrl.sv
// Round sequencer and buzzer arbiter for the two-player quiz game.
// Optional build macro QUIZ_LOCKOUT_EN: a wrong answer locks that player out for the rest of the round.
module quiz_round_ctrl #(
  parameter int BUZZ_TIME   = 200,
  parameter int ANSWER_TIME = 150,
  parameter int NUM_ROUNDS  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       buzzA,
  input  logic       buzzB,
  input  logic       judge_valid,
  input  logic       judge_right,
  output logic [1:0] who,
  output logic       right,
  output logic       score_valid,
  output logic [7:0] count,
  output logic [3:0] round,
  output logic       busy,
  output logic       game_over,
  output logic [2:0] state_dbg
);

  // Scoring handshake: score_valid is a one-cycle strobe with no ready; who and right
  // are stable while it is high, and the consumer must take them in that same cycle.

  typedef enum logic [2:0] {IDLE, OPEN, ANSWER, SCORE, DONE} state_t;

  localparam logic [7:0] BUZZ_LOAD   = 8'(BUZZ_TIME);
  localparam logic [7:0] ANSWER_LOAD = 8'(ANSWER_TIME);
  localparam logic [3:0] LAST_ROUND  = 4'(NUM_ROUNDS);

  state_t     state, state_n;
  logic [1:0] who_n;
  logic       right_n;
  logic [7:0] count_n;
  logic [3:0] round_n;
  logic [1:0] lock, lock_n;   // bit 0 = A, bit 1 = B
  logic       prio, prio_n;   // 0: A wins a tie, 1: B wins a tie
  logic [1:0] valid_buzz;
  logic [1:0] winner;
  logic       round_end;
`ifdef QUIZ_LOCKOUT_EN
  logic [1:0] lock_upd;
`endif

  always_comb begin
    state_n    = state;
    who_n      = who;
    right_n    = right;
    count_n    = count;
    round_n    = round;
    lock_n     = lock;
    prio_n     = prio;
    valid_buzz = {buzzB, buzzA} & ~lock;
    winner     = 2'b00;
    round_end  = 1'b1;
`ifdef QUIZ_LOCKOUT_EN
    lock_upd   = lock;
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = OPEN;
          round_n = 4'd1;
          count_n = BUZZ_LOAD;
          lock_n  = 2'b00;
          who_n   = 2'b00;
          right_n = 1'b0;
        end
      end
      OPEN: begin
        if (valid_buzz != 2'b00) begin
          winner  = (valid_buzz == 2'b11) ? (prio ? 2'b10 : 2'b01) : valid_buzz;
          who_n   = winner;
          prio_n  = (winner == 2'b01);
          count_n = ANSWER_LOAD;
          state_n = ANSWER;
        end else if (count == 8'd0) begin
          who_n   = 2'b00;
          right_n = 1'b0;
          state_n = SCORE;
        end else begin
          count_n = count - 8'd1;
        end
      end
      ANSWER: begin
        // A verdict arriving on the last cycle still counts.
        if (judge_valid) begin
          right_n = judge_right;
          state_n = SCORE;
        end else if (count == 8'd0) begin
          right_n = 1'b0;
          state_n = SCORE;
        end else begin
          count_n = count - 8'd1;
        end
      end
      SCORE: begin
`ifdef QUIZ_LOCKOUT_EN
        if (!right) lock_upd = lock | who;
        round_end = right || (who == 2'b00) || (lock_upd == 2'b11);
`endif
        who_n   = 2'b00;
        right_n = 1'b0;
        if (round_end && (round == LAST_ROUND)) begin
          state_n = DONE;
        end else begin
          state_n = OPEN;
          count_n = BUZZ_LOAD;
          if (round_end) begin
            round_n = round + 4'd1;
            lock_n  = 2'b00;
          end else begin
`ifdef QUIZ_LOCKOUT_EN
            lock_n  = lock_upd;
`endif
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      who         <= 2'b00;
      right       <= 1'b0;
      score_valid <= 1'b0;
      count       <= 8'd0;
      round       <= 4'd0;
      busy        <= 1'b0;
      game_over   <= 1'b0;
      lock        <= 2'b00;
      prio        <= 1'b0;
    end else begin
      state       <= state_n;
      who         <= who_n;
      right       <= right_n;
      score_valid <= (state_n == SCORE);
      count       <= count_n;
      round       <= round_n;
      busy        <= (state_n == OPEN) || (state_n == ANSWER) || (state_n == SCORE);
      game_over   <= (state_n == DONE);
      lock        <= lock_n;
      prio        <= prio_n;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Self-checking bench for quiz_round_ctrl: directed scenarios plus randomized games
// checked against a per-attempt timeline model and an expected-score queue.
`timescale 1ns/1ps
module tb_quiz_round_ctrl;
  localparam int BUZZ = 5;
  localparam int ANS  = 4;
  localparam int NR   = 2;
`ifdef QUIZ_LOCKOUT_EN
  localparam bit LOCKOUT = 1'b1;
`else
  localparam bit LOCKOUT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, buzzA = 1'b0, buzzB = 1'b0;
  logic       judge_valid = 1'b0, judge_right = 1'b0;
  logic [1:0] who;
  logic       right, score_valid;
  logic [7:0] count;
  logic [3:0] round;
  logic       busy, game_over;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: game-level bookkeeping only.
  int         m_round;
  logic       m_prio;
  logic [1:0] m_lock;
  bit         m_done;
  logic [6:0] exp_q[$];   // {round, who, right} of each expected scoring command

  quiz_round_ctrl #(.BUZZ_TIME(BUZZ), .ANSWER_TIME(ANS), .NUM_ROUNDS(NR)) dut (
    .clk(clk), .rst(rst), .start(start), .buzzA(buzzA), .buzzB(buzzB),
    .judge_valid(judge_valid), .judge_right(judge_right), .who(who), .right(right),
    .score_valid(score_valid), .count(count), .round(round), .busy(busy),
    .game_over(game_over), .state_dbg(state_dbg)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; start = 1'b1;
    buzzA = 1'($urandom_range(0, 1)); buzzB = 1'($urandom_range(0, 1));
    judge_valid = 1'($urandom_range(0, 1)); judge_right = 1'($urandom_range(0, 1));
    step();
    rst = 1'b0; start = 1'b0; buzzA = 1'b0; buzzB = 1'b0; judge_valid = 1'b0;
    m_round = 0; m_prio = 1'b0; m_lock = 2'b00; m_done = 1'b0;
    exp_q.delete();
    n_checks++;
    if ({who, right, score_valid, count, round, busy, game_over} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got who=%b right=%b sv=%b count=%0d round=%0d busy=%b go=%b want all 0",
               who, right, score_valid, count, round, busy, game_over);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    buzzA = 1'($urandom_range(0, 1)); buzzB = 1'($urandom_range(0, 1));
    judge_valid = 1'($urandom_range(0, 1));
    step();
    start = 1'b0; buzzA = 1'b0; buzzB = 1'b0; judge_valid = 1'b0;
    m_round = 1; m_lock = 2'b00; m_done = 1'b0;
    n_checks++;
    if ({busy, game_over, score_valid, who, right, round, count} !== {3'b100, 3'b000, 4'd1, 8'(BUZZ)}) begin
      n_fail++;
      $display("FAIL start_state: got busy=%b go=%b sv=%b who=%b right=%b round=%0d count=%0d want busy=1 round=1 count=%0d",
               busy, game_over, score_valid, who, right, round, count, BUZZ);
    end
  endtask

  // One buzz window plus its answer phase, starting just after OPEN was (re)entered.
  // d: buzz arrives d cycles into the window (d > BUZZ means no buzz); req: players buzzing;
  // j: verdict arrives j cycles into the answer window (j > ANS means no verdict).
  task automatic attempt(input int d, input logic [1:0] req, input int j,
                         input logic verdict, output logic [6:0] seen);
    logic [1:0] valid, winner, lock_new, exp_who;
    logic       exp_right, round_end, judged, in_ans;
    int         eb, es, exp_cnt;
    logic [6:0] rec;
    seen = 7'd0;
    valid = (d <= BUZZ) ? (req & ~m_lock) : 2'b00;
    if (valid == 2'b00)      winner = 2'b00;
    else if (valid == 2'b11) winner = m_prio ? 2'b10 : 2'b01;
    else                     winner = valid;
    judged    = (winner != 2'b00) && (j <= ANS);
    exp_right = judged ? verdict : 1'b0;
    if (winner != 2'b00) begin
      eb = d + 1;
      es = judged ? eb + j + 1 : eb + ANS + 1;
      m_prio = (winner == 2'b01);
    end else begin
      eb = 1000;
      es = BUZZ + 1;
    end
    exp_q.push_back({4'(m_round), winner, exp_right});
    lock_new  = m_lock | (((winner != 2'b00) && !exp_right) ? winner : 2'b00);
    round_end = !LOCKOUT || exp_right || (winner == 2'b00) || (lock_new == 2'b11);

    for (int e = 1; e <= es + 1; e++) begin
      in_ans = (winner != 2'b00) && (e > eb) && (e <= es);
      buzzA = 1'b0; buzzB = 1'b0; judge_valid = 1'b0;
      judge_right = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      if ((e == d + 1) && (d <= BUZZ)) {buzzB, buzzA} = req;
      else if (in_ans || (e == es + 1)) {buzzB, buzzA} = 2'($urandom_range(0, 3));
      if (judged && (e == eb + j + 1)) begin
        judge_valid = 1'b1;
        judge_right = verdict;
      end else if (!in_ans) begin
        judge_valid = 1'($urandom_range(0, 1));
      end
      step();
      if (e <= es) begin
        n_checks++;
        if (score_valid !== (e == es)) begin
          n_fail++;
          $display("FAIL score_strobe e=%0d: got %b want %b", e, score_valid, (e == es));
        end
        exp_who = ((winner != 2'b00) && (e >= eb)) ? winner : 2'b00;
        n_checks++;
        if ({who, busy, game_over, round} !== {exp_who, 2'b10, 4'(m_round)}) begin
          n_fail++;
          $display("FAIL round_status e=%0d: got who=%b busy=%b go=%b round=%0d want who=%b busy=1 go=0 round=%0d",
                   e, who, busy, game_over, round, exp_who, m_round);
        end
        if (e < es) begin
          exp_cnt = ((winner == 2'b00) || (e < eb)) ? BUZZ - e : ANS - (e - eb);
          n_checks++;
          if ((count !== 8'(exp_cnt)) || (right !== 1'b0)) begin
            n_fail++;
            $display("FAIL count e=%0d: got count=%0d right=%b want count=%0d right=0", e, count, right, exp_cnt);
          end
        end
        if (score_valid === 1'b1) begin
          n_checks++;
          seen = {round, who, right};
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL score_spurious: got %h want none", seen);
          end else begin
            rec = exp_q.pop_front();
            if (seen !== rec) begin
              n_fail++;
              $display("FAIL score_cmd: got round=%0d who=%b right=%b want round=%0d who=%b right=%b",
                       seen[6:3], seen[2:1], seen[0], rec[6:3], rec[2:1], rec[0]);
            end
          end
        end
      end else begin
        if (round_end) begin
          if (m_round == NR) m_done = 1'b1;
          else begin
            m_round++;
            m_lock = 2'b00;
          end
        end else begin
          m_lock = lock_new;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
          n_fail++;
          $display("FAIL score_missing: got %0d pending want 0", exp_q.size());
          exp_q.delete();
        end
        n_checks++;
        if ({busy, game_over, score_valid, who, right, round} !==
            {~m_done, m_done, 1'b0, 2'b00, 1'b0, 4'(m_round)}) begin
          n_fail++;
          $display("FAIL after_score: got busy=%b go=%b sv=%b who=%b right=%b round=%0d want busy=%b go=%b round=%0d",
                   busy, game_over, score_valid, who, right, round, ~m_done, m_done, m_round);
        end
        if (!m_done) begin
          n_checks++;
          if (count !== 8'(BUZZ)) begin
            n_fail++;
            $display("FAIL reopen_count: got %0d want %0d", count, BUZZ);
          end
        end
      end
    end
    start = 1'b0; buzzA = 1'b0; buzzB = 1'b0; judge_valid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    buzzA = 1'b1; buzzB = 1'b1; judge_valid = 1'b1;
    step();
    buzzA = 1'b0; buzzB = 1'b0; judge_valid = 1'b0;
    n_checks++;
    if ({who, busy, game_over, round, score_valid} !== 9'd0) begin
      n_fail++;
      $display("FAIL idle_hold: got who=%b busy=%b go=%b round=%0d sv=%b want all 0",
               who, busy, game_over, round, score_valid);
    end
  endtask

  task automatic test_reset_mid_answer();
    apply_reset();
    do_start();
    buzzA = 1'b1;
    step();
    buzzA = 1'b0;
    n_checks++;
    if ({who, busy, count} !== {2'b01, 1'b1, 8'(ANS)}) begin
      n_fail++;
      $display("FAIL answer_entry: got who=%b busy=%b count=%0d want who=01 busy=1 count=%0d", who, busy, count, ANS);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_round = 0; m_prio = 1'b0; m_lock = 2'b00; m_done = 1'b0;
    n_checks++;
    if ({who, count, round, busy, score_valid, game_over} !== 17'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got who=%b count=%0d round=%0d busy=%b sv=%b want all 0",
               who, count, round, busy, score_valid);
    end
    do_start();
  endtask

  task automatic test_tie_round_robin();
    logic [6:0] seen;
    apply_reset();
    do_start();
    attempt(0, 2'b11, 1, 1'b1, seen);
    n_checks++;
    if (seen !== {4'd1, 2'b01, 1'b1}) begin
      n_fail++;
      $display("FAIL tie_first: got %h want %h", seen, {4'd1, 2'b01, 1'b1});
    end
    attempt(1, 2'b11, 0, 1'b1, seen);
    n_checks++;
    if (seen !== {4'd2, 2'b10, 1'b1}) begin
      n_fail++;
      $display("FAIL tie_second: got %h want %h", seen, {4'd2, 2'b10, 1'b1});
    end
  endtask

  task automatic test_buzz_timeout();
    logic [6:0] seen;
    apply_reset();
    do_start();
    attempt(BUZZ + 2, 2'b00, 0, 1'b1, seen);
    n_checks++;
    if ({seen[2:0], round} !== {3'b000, 4'd2}) begin
      n_fail++;
      $display("FAIL buzz_timeout: got who=%b right=%b round=%0d want who=00 right=0 round=2", seen[2:1], seen[0], round);
    end
  endtask

  task automatic test_answer_timeout();
    logic [6:0] seen;
    apply_reset();
    do_start();
    attempt(2, 2'b01, ANS + 2, 1'b1, seen);
    n_checks++;
    if (seen[2:0] !== {2'b01, 1'b0}) begin
      n_fail++;
      $display("FAIL answer_timeout: got who=%b right=%b want who=01 right=0", seen[2:1], seen[0]);
    end
    attempt(0, 2'b11, ANS, 1'b1, seen);
    n_checks++;
    if (seen[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL verdict_collision: got right=%b want 1", seen[0]);
    end
  endtask

  task automatic test_lockout();
    logic [6:0] seen;
    apply_reset();
    do_start();
    attempt(1, 2'b01, 0, 1'b0, seen);
    n_checks++;
    if ({seen[2:0], round} !== {3'b010, (LOCKOUT ? 4'd1 : 4'd2)}) begin
      n_fail++;
      $display("FAIL lock_first: got who=%b right=%b round=%0d want who=01 right=0 round=%0d",
               seen[2:1], seen[0], round, (LOCKOUT ? 1 : 2));
    end
    attempt(0, 2'b11, 2, 1'b0, seen);
    n_checks++;
    if ({seen[2:1], round, game_over} !== {2'b10, 4'd2, ~LOCKOUT}) begin
      n_fail++;
      $display("FAIL lock_second: got who=%b round=%0d go=%b want who=10 round=2 go=%b",
               seen[2:1], round, game_over, ~LOCKOUT);
    end
  endtask

  task automatic test_game_end();
    logic [6:0] seen;
    apply_reset();
    do_start();
    attempt(0, 2'b01, 0, 1'b1, seen);
    attempt(3, 2'b10, 1, 1'b1, seen);
    for (int c = 0; c < 3; c++) begin
      buzzA = 1'($urandom_range(0, 1)); buzzB = 1'($urandom_range(0, 1));
      judge_valid = 1'($urandom_range(0, 1));
      step();
      n_checks++;
      if ({game_over, busy, score_valid, who, round} !== {3'b100, 2'b00, 4'(NR)}) begin
        n_fail++;
        $display("FAIL done_hold c=%0d: got go=%b busy=%b sv=%b who=%b round=%0d want go=1 busy=0 round=%0d",
                 c, game_over, busy, score_valid, who, round, NR);
      end
    end
    buzzA = 1'b0; buzzB = 1'b0; judge_valid = 1'b0;
    do_start();
  endtask

  task automatic test_random_games();
    logic [6:0] seen;
    int guard;
    apply_reset();
    for (int g = 0; g < 25; g++) begin
      do_start();
      guard = 0;
      while (!m_done && (guard < 20)) begin
        attempt($urandom_range(0, BUZZ + 2), 2'($urandom_range(0, 3)),
                $urandom_range(0, ANS + 2), 1'($urandom_range(0, 1)), seen);
        guard++;
      end
      n_checks++;
      if (!m_done) begin
        n_fail++;
        $display("FAIL game_length g=%0d: got unfinished after %0d attempts want done", g, guard);
      end
      if ($urandom_range(0, 4) == 0) apply_reset();
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_answer();
    test_tie_round_robin();
    test_buzz_timeout();
    test_answer_timeout();
    test_lockout();
    test_game_end();
    test_random_games();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
